// File: rtl/rv32i_instr_encoder_if.sv
// rv32i_instr_encoder_if: field-bundle handshake, control, imem write bus and status of the encoder
interface rv32i_instr_encoder_if #(
   parameter int CNT_W = 7
);
   logic             start;
   logic             finish;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_class;
   logic [4:0]       in_rd;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic [2:0]       in_funct3;
   logic             in_funct7b5;
   logic [31:0]      in_imm;
   logic             imem_we;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_wdata;
   logic [CNT_W-1:0] word_count;
   logic             busy;
   logic             done;
   logic             full;
   logic             err;
   modport master (
      output start, finish, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
      input  in_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, full, err
   );
   modport slave (
      input  start, finish, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
      output in_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, full, err
   );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: packs decoded RV32I fields into words and writes them sequentially to imem
module rv32i_instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 64,
   parameter int          CNT_W     = 7
) (
   input logic                  clk,
   input logic                  rst,
   rv32i_instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   state_e           state_q, state_d;
   logic             stage_vld_q, stage_vld_d;
   logic [31:0]      stage_word_q, stage_word_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [31:0]      enc_word;
   logic             bad, shift, full, ready, accept, we;
   logic             unused_imm;
   logic [4:0]       rd, rs1, rs2;
   logic [2:0]       f3;
   logic [31:0]      imm;
   assign rd         = bus.in_rd;
   assign rs1        = bus.in_rs1;
   assign rs2        = bus.in_rs2;
   assign f3         = bus.in_funct3;
   assign imm        = bus.in_imm;
   assign unused_imm = ^imm[31:21];
   assign shift      = f3[1:0] == 2'b01;
   assign full       = cnt_q == CNT_W'(DEPTH);
   assign ready      = (state_q == RUN) && !full && !bus.finish;
   assign accept     = bus.in_valid && ready;
   // A staged word past DEPTH, or one caught by start/rst, is dropped rather than written
   assign we         = stage_vld_q && !full && !bus.start && !rst;
   assign bus.in_ready   = ready;
   assign bus.imem_we    = we;
   assign bus.imem_addr  = we ? addr_q : '0;
   assign bus.imem_wdata = we ? stage_word_q : '0;
   assign bus.word_count = cnt_q;
   assign bus.busy       = state_q == RUN;
   assign bus.done       = state_q == DONE;
   assign bus.full       = full;
   assign bus.err        = err_q;
   // Pack the incoming field bundle; flag illegal classes and odd branch/jump offsets
   always_comb begin
      enc_word = '0;
      bad      = 1'b0;
      case (bus.in_class)
         3'd0: enc_word = {bus.in_funct7b5 ? 7'b0100000 : 7'b0000000, rs2, rs1, f3, rd, 7'b0110011};
         3'd1: enc_word = {shift ? {1'b0, bus.in_funct7b5, 5'b0, imm[4:0]} : imm[11:0], rs1, f3, rd, 7'b0010011};
         3'd2: enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
         3'd3: enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
         3'd4: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            bad      = imm[0];
         end
         3'd5: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            bad      = imm[0];
         end
         default: bad = 1'b1;
      endcase
   end
   // Next state: write bookkeeping, staging, FSM sequencing; start overrides everything
   always_comb begin
      state_d      = state_q;
      stage_vld_d  = 1'b0;
      stage_word_d = stage_word_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      if (we) begin
         addr_d = addr_q + 32'd4;
         cnt_d  = cnt_q + CNT_W'(1);
      end
      if (accept) begin
         if (bad) err_d = 1'b1;
         else begin
            stage_vld_d  = 1'b1;
            stage_word_d = enc_word;
         end
      end
      unique case (state_q)
         IDLE:  state_d = state_q;
         RUN:   if (bus.finish) state_d = stage_vld_q ? DRAIN : DONE;
         DRAIN: if (!stage_vld_q) state_d = DONE;
         DONE:  state_d = state_q;
      endcase
      if (bus.start) begin
         state_d     = RUN;
         stage_vld_d = 1'b0;
         addr_d      = BASE_ADDR;
         cnt_d       = '0;
         err_d       = 1'b0;
      end
   end
   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         stage_vld_q  <= 1'b0;
         stage_word_q <= '0;
         addr_q       <= BASE_ADDR;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         stage_vld_q  <= stage_vld_d;
         stage_word_q <= stage_word_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder: directed vectors checked by a cycle model plus literal write-log expectations
module tb_rv32i_instr_encoder;
   localparam int          DEPTH = 4;
   localparam int          CNT_W = 3;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] log_a[$];
   logic [31:0] log_d[$];
   int          m_st;
   int          m_cnt;
   logic [31:0] m_addr;
   logic [31:0] m_word;
   bit          m_err;
   bit          m_stg;
   always #5 clk = ~clk;
   rv32i_instr_encoder_if #(.CNT_W(CNT_W)) bus();
   rv32i_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] enc(int cls, int rd, int rs1, int rs2, int f3, int f7, logic [31:0] imm);
      logic [31:0] r;
      logic [31:0] lo;
      lo = 32'((rs1 << 15) | (f3 << 12));
      case (cls)
         0: r = 32'((f7 << 30) | (rs2 << 20) | (rd << 7)) | lo | 32'h33;
         1: r = (((f3 == 1 || f3 == 5) ? (32'(f7 << 10) | (imm & 32'd31)) : (imm & 32'hFFF)) << 20) | 32'(rd << 7) | lo | 32'h13;
         2: r = ((imm & 32'hFFF) << 20) | 32'(rd << 7) | lo | 32'h03;
         3: r = (((imm >> 5) & 32'd127) << 25) | 32'(rs2 << 20) | lo | ((imm & 32'd31) << 7) | 32'h23;
         4: r = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | 32'(rs2 << 20) | lo
                | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'h63;
         5: r = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) | (((imm >> 11) & 32'd1) << 20)
                | (((imm >> 12) & 32'd255) << 12) | 32'(rd << 7) | 32'h6F;
         default: r = '0;
      endcase
      return r;
   endfunction
   always @(negedge clk) begin : cmp
      bit ef, er, ewe, acc, bad, old_stg;
      int cls;
      if (bus.imem_we) begin
         log_a.push_back(bus.imem_addr);
         log_d.push_back(bus.imem_wdata);
      end
      if (rst) begin
         m_st = 0; m_cnt = 0; m_addr = BASE; m_word = '0; m_err = 0; m_stg = 0;
      end else begin
         ef  = m_cnt == DEPTH;
         er  = m_st == 1 && !ef && !bus.finish;
         ewe = m_stg && !ef && !bus.start;
         chk("in_ready", 32'(bus.in_ready), 32'(er));
         chk("imem_we", 32'(bus.imem_we), 32'(ewe));
         chk("imem_addr", bus.imem_addr, ewe ? m_addr : 32'h0);
         chk("imem_wdata", bus.imem_wdata, ewe ? m_word : 32'h0);
         chk("word_count", 32'(bus.word_count), 32'(m_cnt));
         chk("busy", 32'(bus.busy), 32'(m_st == 1));
         chk("done", 32'(bus.done), 32'(m_st == 3));
         chk("full", 32'(bus.full), 32'(ef));
         chk("err", 32'(bus.err), 32'(m_err));
         cls = int'(bus.in_class);
         acc = bus.in_valid && er;
         bad = cls >= 6 || ((cls == 4 || cls == 5) && bus.in_imm[0]);
         old_stg = m_stg;
         if (ewe) begin
            m_addr += 4;
            m_cnt++;
         end
         m_stg = 0;
         if (acc) begin
            if (bad) m_err = 1;
            else begin
               m_stg  = 1;
               m_word = enc(cls, int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                            int'(bus.in_funct3), int'(bus.in_funct7b5), bus.in_imm);
            end
         end
         if (m_st == 1 && bus.finish) m_st = old_stg ? 2 : 3;
         else if (m_st == 2) m_st = 3;
         if (bus.start) begin
            m_st = 1; m_cnt = 0; m_addr = BASE; m_err = 0; m_stg = 0;
         end
      end
   end
   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(int cls, int rd, int rs1, int rs2, int f3, int f7, logic [31:0] imm);
      bus.in_valid    = 1'b1;
      bus.in_class    = 3'(cls);
      bus.in_rd       = 5'(rd);
      bus.in_rs1      = 5'(rs1);
      bus.in_rs2      = 5'(rs2);
      bus.in_funct3   = 3'(f3);
      bus.in_funct7b5 = 1'(f7);
      bus.in_imm      = imm;
      cyc(1);
      bus.in_valid    = 1'b0;
   endtask
   task automatic pulse_start();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
   endtask
   task automatic pulse_finish();
      bus.finish = 1'b1;
      cyc(1);
      bus.finish = 1'b0;
   endtask
   task automatic expw(int i, logic [31:0] a, logic [31:0] d);
      chk($sformatf("log_addr[%0d]", i), log_a[i], a);
      chk($sformatf("log_data[%0d]", i), log_d[i], d);
   endtask
   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask
   initial begin
      bus.start = 0; bus.finish = 0; bus.in_valid = 0; bus.in_class = 0; bus.in_rd = 0;
      bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_funct3 = 0; bus.in_funct7b5 = 0; bus.in_imm = 0;
      chk("pin_add",  enc(0, 3, 1, 2, 0, 0, 0), 32'h002081B3);
      chk("pin_sub",  enc(0, 3, 1, 2, 0, 1, 0), 32'h402081B3);
      chk("pin_addi", enc(1, 5, 0, 0, 0, 0, 32'hFFFF_FFFF), 32'hFFF00293);
      chk("pin_srai", enc(1, 1, 2, 0, 5, 1, 32'hFFFF_FFE3), 32'h40315093);
      chk("pin_lw",   enc(2, 5, 2, 0, 2, 0, 4), 32'h00412283);
      chk("pin_sw",   enc(3, 0, 1, 2, 2, 0, 8), 32'h0020A423);
      chk("pin_beq",  enc(4, 0, 1, 2, 0, 0, 32'hFFFF_FFFC), 32'hFE208EE3);
      chk("pin_jal",  enc(5, 1, 0, 0, 0, 0, 8), 32'h008000EF);
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_count", 32'(bus.word_count), 0);
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk("rst_we", 32'(bus.imem_we), 0);
      clear_log();
      pulse_start();
      send(0, 3, 1, 2, 0, 0, 0);
      send(0, 3, 1, 2, 0, 1, 0);
      cyc(2);
      chk("r_nwr", log_d.size(), 2);
      expw(0, 32'h0, 32'h002081B3);
      expw(1, 32'h4, 32'h402081B3);
      chk("r_count", 32'(bus.word_count), 2);
      clear_log();
      pulse_start();
      send(1, 5, 0, 0, 0, 0, 32'hFFFF_FFFF);
      send(2, 5, 2, 0, 2, 0, 4);
      send(1, 1, 2, 0, 5, 1, 32'hFFFF_FFE3);
      cyc(2);
      chk("il_nwr", log_d.size(), 3);
      expw(0, 32'h0, 32'hFFF00293);
      expw(1, 32'h4, 32'h00412283);
      expw(2, 32'h8, 32'h40315093);
      clear_log();
      pulse_start();
      send(3, 0, 1, 2, 2, 0, 8);
      send(4, 0, 1, 2, 0, 0, 32'hFFFF_FFFC);
      send(5, 1, 0, 0, 0, 0, 8);
      cyc(2);
      chk("sbj_nwr", log_d.size(), 3);
      expw(0, 32'h0, 32'h0020A423);
      expw(1, 32'h4, 32'hFE208EE3);
      expw(2, 32'h8, 32'h008000EF);
      chk("sbj_count", 32'(bus.word_count), 3);
      clear_log();
      pulse_start();
      send(0, 3, 1, 2, 0, 0, 0);
      send(6, 1, 1, 1, 0, 0, 0);
      send(4, 0, 1, 2, 0, 0, 3);
      cyc(2);
      chk("err_nwr", log_d.size(), 1);
      chk("err_set", 32'(bus.err), 1);
      chk("err_count", 32'(bus.word_count), 1);
      pulse_start();
      chk("err_clr", 32'(bus.err), 0);
      clear_log();
      for (int i = 0; i < 6; i++) send(1, 1, 0, 0, 0, 0, 32'(i));
      cyc(2);
      chk("full_nwr", log_d.size(), 4);
      for (int i = 0; i < 4; i++) expw(i, 32'(4 * i), 32'(i << 20) | 32'h93);
      chk("full_flag", 32'(bus.full), 1);
      chk("full_ready", 32'(bus.in_ready), 0);
      chk("full_count", 32'(bus.word_count), 4);
      clear_log();
      pulse_start();
      send(0, 3, 1, 2, 0, 0, 0);
      pulse_finish();
      chk("drain_busy", 32'(bus.busy), 0);
      chk("drain_done", 32'(bus.done), 0);
      cyc(1);
      chk("drain_to_done", 32'(bus.done), 1);
      chk("drain_nwr", log_d.size(), 1);
      expw(0, 32'h0, 32'h002081B3);
      clear_log();
      pulse_start();
      send(0, 3, 1, 2, 0, 0, 0);
      pulse_start();
      cyc(1);
      chk("restart_nwr", log_d.size(), 0);
      chk("restart_count", 32'(bus.word_count), 0);
      send(0, 3, 1, 2, 0, 1, 0);
      cyc(1);
      chk("restart_nwr2", log_d.size(), 1);
      expw(0, 32'h0, 32'h402081B3);
      clear_log();
      bus.finish = 1'b1;
      send(0, 3, 1, 2, 0, 0, 0);
      bus.finish = 1'b0;
      cyc(1);
      chk("fin_acc_nwr", log_d.size(), 0);
      chk("fin_acc_done", 32'(bus.done), 1);
      pulse_finish();
      chk("fin_idle_done", 32'(bus.done), 1);
      pulse_start();
      send(0, 3, 1, 2, 0, 0, 0);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(1);
      chk("rst_mid_nwr", log_d.size(), 0);
      chk("rst_mid_busy", 32'(bus.busy), 0);
      chk("rst_mid_count", 32'(bus.word_count), 0);
      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Field-to-word RV32I instruction encoder and instruction-memory loader; the producing end of the instruction word that the core's main/ALU decoders consume. Accepts one decoded-field instruction per valid/ready handshake, packs it into a 32-bit RV32I word, and writes it sequentially into instruction memory from BASE_ADDR upward. Used by the test harness and boot path to build programs without an external assembler.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first written word
DEPTH, 64, maximum words per program; writes beyond this are refused
CNT_W, 7, width of word_count; must satisfy 2^CNT_W > DEPTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; clears count/err, sets address to BASE_ADDR, enters RUN
finish  in  1  pulse; end of program; DONE once the pipeline drains
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept this cycle
in_class  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6/7=illegal
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_funct3  in  3  funct3
in_funct7b5  in  1  instr[30] (SUB/SRA/SRAI select)
in_imm  in  32  sign-extended immediate, byte offset for BRANCH/JAL
imem_we  out  1  instruction-memory write strobe
imem_addr  out  32  byte address, word-aligned
imem_wdata  out  32  encoded instruction
word_count  out  CNT_W  words written since start
busy  out  1  state==RUN
done  out  1  state==DONE
full  out  1  word_count==DEPTH
err  out  1  sticky: illegal class or misaligned BRANCH/JAL offset

Behaviour:
- Reset: state IDLE; all outputs 0; stage register empty; next address BASE_ADDR.
- FSM: IDLE -start-> RUN; RUN -finish-> DRAIN (if stage full) else DONE; DRAIN -> DONE after the staged write issues; DONE -start-> RUN. start in any state restarts: count=0, err=0, address=BASE_ADDR, the staged word is discarded (imem_we=0 that cycle).
- in_ready = (state==RUN) && !full && !finish. Handshake fires on in_valid && in_ready; in_valid while in_ready=0 is ignored, not queued.
- Latency: one cycle. Accepted bundle is registered into the stage; next cycle imem_we=1, imem_addr=current address, imem_wdata=encoded word; address += 4 and word_count += 1 on that edge. Sustains one word per cycle.
- Encodings ({} MSB first):
  R: {f7b5?7'b0100000:7'b0, rs2, rs1, f3, rd, 0110011}
  I-ALU: {imm[11:0], rs1, f3, rd, 0010011}; for f3=001/101 bits[31:25]={1'b0, f7b5, 5'b0}, bits[24:20]=imm[4:0]
  LOAD: {imm[11:0], rs1, f3, rd, 0000011}
  STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}
  BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}
  JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
- Immediate bits above the field width are ignored (no range check).
- Error: class 6/7, or BRANCH/JAL with imm[0]=1 -> handshake completes, no write, count unchanged, err set until start/rst.
- full: when word_count reaches DEPTH, in_ready drops the same cycle full rises; count never exceeds DEPTH; full clears only on start.
- finish and accept in the same cycle: in_ready already 0, bundle not accepted. finish outside RUN ignored.
- rst mid-RUN: staged write dropped, returns to IDLE.

Test Plan:
- start; send R add x3,x1,x2 then R f7b5=1 -> writes 0x002081B3 @0x0, 0x402081B3 @0x4 on consecutive cycles; word_count=2.
- I-ALU addi x5,x0,imm=-1; LOAD lw x5,4(x2) -> 0xFFF00293, 0x00412283.
- STORE sw x2,8(x1); BRANCH beq x1,x2,imm=-4; JAL x1,imm=8 -> 0x0020A423, 0xFE208EE3, 0x008000EF.
- in_class=6, then BRANCH imm=3 -> both accepted, no imem_we, err=1, count unchanged; start clears err.
- DEPTH=4: hold in_valid for 6 words -> exactly 4 writes (0x0..0xC), full=1, in_ready=0 afterwards.
- Accept word, finish next cycle -> DRAIN, write issues, then done=1; start during a staged word -> no write, count=0, addr restarts at BASE_ADDR.
